axis_uart_tx: RTL and testbench
===============================

// Module: axis_uart_tx
// PURPOSE
//   AXI-Stream slave to UART serial transmitter. Consumes bytes from an AXIS master and shifts
//   them out on a single UART line: start bit, data LSB-first, optional parity, stop bit(s).
//   It is the transmit end of the UART link. A tlast-marked byte closes a frame and can insert
//   an idle gap on the line. Sits between the packet source and the tx pad.
// PARAMETERS
//   DATA_WIDTH  8   data bits per character; s_axis_tdata width
//   CLK_DIV     16  clk cycles per bit period; legal range >= 2
//   PARITY      0   0 = none, 1 = odd, 2 = even
//   STOP_BITS   1   stop bits per character; 1 or 2
//   FRAME_GAP   0   extra idle bit periods (tx=1) after a tlast byte; 0 = none
// PORTS
//   clk            in   1           system clock, rising edge
//   rst            in   1           synchronous reset, active high
//   s_axis_tdata   in   DATA_WIDTH  byte to transmit
//   s_axis_tvalid  in   1           tdata/tlast valid
//   s_axis_tready  out  1           block accepts a byte this cycle
//   s_axis_tlast   in   1           byte is the last of its frame
//   tx             out  1           UART serial line; idle high
//   busy           out  1           character or gap in progress
//   frame_done     out  1           1-cycle pulse when the tlast character (and its gap) completes
// BEHAVIOUR
//   - Reset (rst=1 at an edge): tx=1, s_axis_tready=0, busy=0, frame_done=0, state=IDLE,
//     counters cleared. Reset mid-character aborts it; tx returns high at the reset edge and the
//     byte is lost. s_axis_tready is 1 from the first cycle after rst deasserts.
//   - Handshake: s_axis_tready = (state==IDLE) && !rst. A transfer occurs only on an edge with
//     tvalid && tready. tdata and tlast are latched at that edge. No transfer while tready=0;
//     tvalid may be held or dropped freely.
//   - FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
//     - IDLE->START on transfer. At the same edge tx<=0 and busy<=1.
//     - START->DATA after CLK_DIV cycles.
//     - DATA: DATA_WIDTH bits, LSB first, each CLK_DIV cycles, then go to PARITY (if PARITY!=0)
//       or STOP.
//     - PARITY: one bit period. Odd: tx = ~^data. Even: tx = ^data.
//     - STOP: STOP_BITS*CLK_DIV cycles with tx=1.
//     - After STOP: go to GAP if tlast was latched and FRAME_GAP>0, otherwise go to IDLE.
//     - GAP: FRAME_GAP*CLK_DIV cycles with tx=1, then go to IDLE.
//   - Outputs are registered. tx changes only on bit-period boundaries.
//   - frame_done pulses at the edge entering IDLE from a tlast character. busy<=0 at that
//     same edge.
//   - Counters: baud counter runs 0..CLK_DIV-1 and wraps at the bit boundary. Bit counter is
//     $clog2(DATA_WIDTH+1) wide.
//   - Character time = (1+DATA_WIDTH+(PARITY!=0)+STOP_BITS)*CLK_DIV cycles.
//   - Back-to-back: with tvalid held high, consecutive handshakes are exactly character time + 1
//     cycles apart. The extra cycle is the one IDLE cycle, with tx=1.
//   - tvalid asserted during reset: no transfer. tvalid low in IDLE: tx stays 1 indefinitely.
// TESTING (DATA_WIDTH=8, CLK_DIV=4 unless noted)
//   1. PARITY=0: send 0xA5 with tlast=1.
//      -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
//      -> tready low for 40 cycles after the handshake.
//      -> frame_done pulses once at cycle 40; busy then falls.
//   2. tvalid held high with 0x00 then 0xFF.
//      -> handshakes are 41 cycles apart.
//      -> tx shows one extra high cycle between the stop bit and the second start bit.
//   3. Parity on 0x07.
//      -> PARITY=2: parity bit = 1.
//      -> PARITY=1: parity bit = 0.
//      -> STOP_BITS=2: stop high for 8 cycles; character time = 48.
//   4. FRAME_GAP=2: send 0x3C with tlast=1.
//      -> tx high and tready low for 8 extra cycles after the stop bit.
//      -> frame_done pulses at cycle 48.
//      -> a tlast=0 byte inserts no gap and produces no frame_done.
//   5. Assert rst for 1 cycle during data bit 3 of 0x55.
//      -> tx=1 and tready=0 in the reset cycle.
//      -> next byte 0x81 is accepted the cycle after reset and transmitted correctly.
//   6. Random tvalid gaps on a 16-byte frame (random tlast placement):
//      -> decoded line stream equals the sent bytes in order.
//      -> no byte is accepted while busy.
//      -> frame_done count equals the number of tlast bytes.

Source files
------------

// File: rtl/axis_uart_tx.sv
// AXI-Stream slave to UART transmitter.
// Accepts one character per handshake and shifts it out on tx as a start bit, DATA_WIDTH data
// bits LSB first, an optional parity bit and STOP_BITS stop bits. A character latched with
// tlast closes a frame: it may be followed by FRAME_GAP idle bit periods, and frame_done
// pulses once when the frame (including its gap) has finished.
module axis_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FRAME_GAP  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam int GAP_W  = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } state_t;

  state_t                state, state_next;
  logic [BAUD_W-1:0]     baud_cnt, baud_next;
  logic [BIT_W-1:0]      bit_cnt, bit_next;
  logic [GAP_W-1:0]      gap_cnt, gap_next;
  logic [DATA_WIDTH-1:0] shift_q, shift_next;
  logic                  last_q;
  logic                  par_q;
  logic                  tx_next;
  logic                  busy_next;
  logic                  done_next;
  logic                  baud_end;
  logic                  handshake;

  // The block only listens while idle, and never while reset is being applied.
  assign s_axis_tready = (state == ST_IDLE) && !rst;
  assign handshake     = s_axis_tvalid && s_axis_tready;
  assign baud_end      = (baud_cnt == BAUD_LAST);

  // State, counters, latched character and registered line outputs.
  // NOTE: every register here is written with <= so all of them sample the pre-edge values
  // computed by the combinational processes, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      shift_q    <= '0;
      last_q     <= 1'b0;
      par_q      <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_cnt    <= bit_next;
      gap_cnt    <= gap_next;
      shift_q    <= shift_next;
      tx         <= tx_next;
      busy       <= busy_next;
      frame_done <= done_next;
      if (handshake) begin
        last_q <= s_axis_tlast;
        par_q  <= (PARITY == 1) ? ~^s_axis_tdata : ^s_axis_tdata;
      end
    end
  end

  // Next-state logic: walks the character one bit period at a time.
  // NOTE: every signal assigned below gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_next = state;
    baud_next  = (state == ST_IDLE || baud_end) ? '0 : baud_cnt + 1'b1;
    bit_next   = bit_cnt;
    gap_next   = gap_cnt;
    shift_next = shift_q;
    case (state)
      ST_IDLE: begin
        if (handshake) begin
          state_next = ST_START;
          shift_next = s_axis_tdata;
        end
      end
      ST_START: begin
        if (baud_end) begin
          state_next = ST_DATA;
          bit_next   = '0;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          if (bit_cnt == DATA_LAST) begin
            state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
            bit_next   = '0;
          end else begin
            bit_next   = bit_cnt + 1'b1;
            shift_next = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_end) begin
          state_next = ST_STOP;
          bit_next   = '0;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          if (bit_cnt == STOP_LAST) begin
            state_next = (last_q && (FRAME_GAP > 0)) ? ST_GAP : ST_IDLE;
            gap_next   = '0;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (baud_end) begin
          if (gap_cnt == GAP_LAST) state_next = ST_IDLE;
          else                     gap_next   = gap_cnt + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic: line level and status for the state being entered at the next edge.
  always_comb begin
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
      ST_PARITY: tx_next = par_q;
      default:   tx_next = 1'b1;
    endcase
    busy_next = (state_next != ST_IDLE);
    done_next = (state != ST_IDLE) && (state_next == ST_IDLE) && last_q;
  end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Self-checking bench for axis_uart_tx. Four instances cover the parameter sets of interest:
//   0: no parity, 1 stop, no gap    1: even parity, 2 stops
//   2: odd parity, 1 stop           3: no parity, 1 stop, 2-period frame gap
// Accepted bytes go into a scoreboard queue; a per-instance line decoder rebuilds each
// character from tx and compares it against the front of the queue.
module tb_axis_uart_tx;

  localparam time PERIOD = 10;

  logic clk = 1'b0;
  always #(PERIOD / 2) clk = ~clk;

  logic       rst;
  logic [7:0] tdata  [4];
  logic       tvalid [4];
  logic       tlast  [4];
  logic       tready [4];
  logic       tx     [4];
  logic       busy   [4];
  logic       fdone  [4];

  typedef struct packed {
    logic [1:0] inst;
    logic [7:0] data;
  } sb_item_t;

  sb_item_t exp_q [$];
  int n_checks = 0;
  int n_errors = 0;
  int exp_fd [4] = '{default: 0};
  int got_fd [4] = '{default: 0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference character: start, data LSB first, optional parity, then ones (stop/idle).
  function automatic logic [11:0] char_bits(input logic [7:0] d, input int par);
    logic [11:0] v;
    v      = '1;
    v[0]   = 1'b0;
    v[8:1] = d;
    if (par == 1)      v[9] = ~^d;
    else if (par == 2) v[9] = ^d;
    return v;
  endfunction

  // Expected tx per clock cycle after a handshake, CLK_DIV = 4.
  function automatic logic [63:0] line_wave(input logic [7:0] d, input int par);
    logic [11:0] cb;
    logic [63:0] w;
    cb = char_bits(d, par);
    for (int c = 0; c < 64; c++) w[c] = (c / 4 < 12) ? cb[c / 4] : 1'b1;
    return w;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int P  = (g == 1) ? 2 : (g == 2) ? 1 : 0;
    localparam int S  = (g == 1) ? 2 : 1;
    localparam int G  = (g == 3) ? 2 : 0;
    localparam int NB = 1 + 8 + ((P != 0) ? 1 : 0) + S;

    axis_uart_tx #(
      .DATA_WIDTH(8),
      .CLK_DIV   (4),
      .PARITY    (P),
      .STOP_BITS (S),
      .FRAME_GAP (G)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .s_axis_tdata (tdata[g]),
      .s_axis_tvalid(tvalid[g]),
      .s_axis_tready(tready[g]),
      .s_axis_tlast (tlast[g]),
      .tx           (tx[g]),
      .busy         (busy[g]),
      .frame_done   (fdone[g])
    );

    int          cnt = -1;
    logic [11:0] bits;
    sb_item_t    e;

    // Line decoder: samples mid-bit, abandons a character on reset.
    always @(negedge clk) begin : dec
      if (rst === 1'b1) cnt = -1;
      else if (cnt < 0) begin
        if (tx[g] === 1'b0) begin
          cnt  = 0;
          bits = '1;
        end
      end else cnt++;
      if (cnt >= 0 && (cnt % 4) == 2) begin
        bits[cnt / 4] = tx[g];
        if (cnt / 4 == NB - 1) begin
          check($sformatf("dec_avail%0d", g), 64'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("dec_inst%0d", g), e.inst, g);
            check($sformatf("dec_frame%0d", g), bits, char_bits(e.data, P));
          end
          cnt = -1;
        end
      end
    end
  end

  // Handshake monitor: pushes accepted bytes, counts frame_done pulses.
  always @(negedge clk) begin : hs_mon
    sb_item_t it;
    if (rst === 1'b1) exp_q.delete();
    for (int g = 0; g < 4; g++) begin
      if (tvalid[g] === 1'b1 && tready[g] === 1'b1) begin
        check($sformatf("busy_at_hs%0d", g), busy[g], 0);
        it.inst = 2'(g);
        it.data = tdata[g];
        exp_q.push_back(it);
        if (tlast[g]) exp_fd[g]++;
      end
      if (fdone[g] === 1'b1) got_fd[g]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int g, input logic [7:0] d, input logic last, input bit hold,
                      output time t_hs, output logic tx_at_hs);
    bit done;
    done     = 1'b0;
    t_hs     = 0;
    tx_at_hs = 1'bx;
    tdata[g]  = d;
    tlast[g]  = last;
    tvalid[g] = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (tready[g] === 1'b1) begin
        tx_at_hs = tx[g];
        @(posedge clk);
        t_hs = $time;
        #1;
        if (!hold) tvalid[g] = 1'b0;
        done = 1'b1;
      end
    end
    check("hs_timeout", done, 1);
  endtask

  task automatic observe(input int g, input int n,
                         output logic [63:0] txv, output logic [63:0] rdyv,
                         output logic [63:0] fdv, output logic [63:0] bsv);
    txv = '0; rdyv = '0; fdv = '0; bsv = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      txv[c]  = tx[g];
      rdyv[c] = tready[g];
      fdv[c]  = fdone[g];
      bsv[c]  = busy[g];
    end
  endtask

  task automatic drain();
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 400 && !idle; n++) begin
      @(negedge clk);
      idle = (exp_q.size() == 0) && !busy[0] && !busy[1] && !busy[2] && !busy[3];
    end
    check("drain", idle, 1);
    tick();
  endtask

  initial begin : watchdog
    #(PERIOD * 20000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [63:0] txv, rdyv, fdv, bsv, w;
    time         t1, t2, t_rst;
    logic        txs;
    logic [7:0]  d;
    logic        last;

    rst = 1'b1;
    for (int g = 0; g < 4; g++) begin
      tdata[g] = '0; tvalid[g] = 1'b0; tlast[g] = 1'b0;
    end
    tvalid[0] = 1'b1;
    tdata[0]  = 8'hEE;
    repeat (3) tick();
    @(negedge clk);
    check("rst_tready", tready[0], 0);
    check("rst_tx", tx[0], 1);
    check("rst_busy", busy[0], 0);
    check("rst_fdone", fdone[0], 0);
    tick();
    rst       = 1'b0;
    tvalid[0] = 1'b0;

    // Idle line with no traffic
    observe(0, 20, txv, rdyv, fdv, bsv);
    check("idle_tready", rdyv[19:0], 20'hFFFFF);
    check("idle_tx", txv[19:0], 20'hFFFFF);
    check("idle_busy", bsv[19:0], 0);
    tick();

    // 1: 0xA5 with tlast, no parity
    send(0, 8'hA5, 1'b1, 1'b0, t1, txs);
    observe(0, 42, txv, rdyv, fdv, bsv);
    w = line_wave(8'hA5, 0);
    check("t1_tx", txv[39:0], w[39:0]);
    check("t1_rdy_low", rdyv[39:0], 0);
    check("t1_rdy_back", rdyv[40], 1);
    check("t1_fdone", fdv[41:0], 64'd1 << 40);
    check("t1_busy", bsv[40:0], 64'h00FF_FFFF_FFFF);
    drain();

    // 2: back-to-back with tvalid held
    send(0, 8'h00, 1'b0, 1'b1, t1, txs);
    send(0, 8'hFF, 1'b1, 1'b0, t2, txs);
    check("t2_spacing", (t2 - t1) / PERIOD, 41);
    check("t2_idle_tx", txs, 1);
    @(negedge clk);
    check("t2_start", tx[0], 0);
    drain();

    // 3: parity on 0x07 (even with 2 stops, then odd)
    send(1, 8'h07, 1'b0, 1'b0, t1, txs);
    observe(1, 50, txv, rdyv, fdv, bsv);
    w = line_wave(8'h07, 2);
    check("t3e_line", txv[47:0], w[47:0]);
    check("t3e_parity", txv[37], 1);
    check("t3e_stop", txv[47:40], 8'hFF);
    check("t3e_rdy", rdyv[48:47], 2'b10);
    drain();
    send(2, 8'h07, 1'b0, 1'b0, t1, txs);
    observe(2, 46, txv, rdyv, fdv, bsv);
    w = line_wave(8'h07, 1);
    check("t3o_line", txv[43:0], w[43:0]);
    check("t3o_parity", txv[37], 0);
    check("t3o_rdy", rdyv[44:43], 2'b10);
    drain();

    // 4: frame gap after a tlast byte, none after a plain byte
    send(3, 8'h3C, 1'b1, 1'b0, t1, txs);
    observe(3, 50, txv, rdyv, fdv, bsv);
    w = line_wave(8'h3C, 0);
    check("t4_line", txv[47:0], w[47:0]);
    check("t4_gap_tx", txv[47:40], 8'hFF);
    check("t4_rdy", rdyv[48:0], 64'd1 << 48);
    check("t4_fdone", fdv[49:0], 64'd1 << 48);
    drain();
    send(3, 8'h11, 1'b0, 1'b0, t1, txs);
    observe(3, 42, txv, rdyv, fdv, bsv);
    check("t4_nogap_rdy", rdyv[40], 1);
    check("t4_nogap_fdone", fdv[41:0], 0);
    drain();

    // 5: reset during data bit 3 of 0x55, then 0x81
    send(0, 8'h55, 1'b0, 1'b0, t1, txs);
    repeat (17) tick();
    rst = 1'b1;
    @(negedge clk);
    check("t5_rdy_in_rst", tready[0], 0);
    tick();
    t_rst = $time - 1;
    rst   = 1'b0;
    send(0, 8'h81, 1'b1, 1'b0, t2, txs);
    check("t5_tx_after_rst", txs, 1);
    check("t5_accept", (t2 - t_rst) / PERIOD, 1);
    drain();

    // 6: 16-byte frame with random tvalid gaps and random tlast placement
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 6)) tick();
      d    = 8'($urandom);
      last = (i == 15) || ($urandom_range(0, 3) == 0);
      send(0, d, last, 1'b0, t1, txs);
    end
    drain();
    repeat (4) tick();

    check("sb_empty", exp_q.size(), 0);
    for (int g = 0; g < 4; g++)
      check($sformatf("fd_count%0d", g), got_fd[g], exp_fd[g]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
